alu_issue_ctrl: RTL and testbench

Multi-cycle issue/writeback controller that sits directly upstream and downstream of the 8-bit ALU. It accepts one 16-bit instruction per handshake and reads operands from an internal 4x8 register file. It drives the ALU operand/opcode inputs, then captures the ALU result and flags and writes them back to the register file and a flags register. The ALU is instantiated outside this block and connected through the `alu_*` ports.

---
 rtl/alu_pkg.sv | 56 +++++
 rtl/reg_file_4x8.sv | 39 +++
 rtl/alu_issue_ctrl.sv | 143 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU issue/writeback path.
// Holds ALU opcode encodings, the issue FSM state type, instruction field
// bit positions, flag indices and the packed flag payload.
package alu_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned ALU_OP_W   = 4;
    localparam int unsigned OP_FIELD_W = 3;
    localparam int unsigned IMM_W      = 4;
    localparam int unsigned REG_IDX_W  = 2;
    localparam int unsigned NUM_REGS   = 4;
    localparam int unsigned FLAG_W     = 4;

    // ALU opcode encodings as presented on alu_op
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_NOT = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SHL = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SHR = 4'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } issue_state_e;

    // Instruction word field positions; bits [7:4] are reserved
    localparam int unsigned INSTR_IMM_FLAG_BIT = 15;
    localparam int unsigned INSTR_OP_MSB       = 14;
    localparam int unsigned INSTR_OP_LSB       = 12;
    localparam int unsigned INSTR_RD_MSB       = 11;
    localparam int unsigned INSTR_RD_LSB       = 10;
    localparam int unsigned INSTR_RS_MSB       = 9;
    localparam int unsigned INSTR_RS_LSB       = 8;
    localparam int unsigned INSTR_IMM_MSB      = 3;
    localparam int unsigned INSTR_IMM_LSB      = 0;

    // Bit positions inside the 4-bit flags word {C, Z, V, U}
    localparam int unsigned FLAG_C = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_U = 0;

    typedef struct packed {
        logic c;
        logic z;
        logic v;
        logic u;
    } alu_flags_t;

endpackage

// File: rtl/reg_file_4x8.sv
// reg_file_4x8: 4-entry x 8-bit register file.
// Ports: clk, rst_n (async active-low, clears all entries);
//        rd_sel_a/rd_data_a_c, rd_sel_b/rd_data_b_c: combinational read ports;
//        dbg_sel/dbg_data_c: combinational debug read port;
//        wr_en/wr_sel/wr_data: synchronous write port.
module reg_file_4x8
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] rd_sel_a,
    output logic [DATA_W-1:0]    rd_data_a_c,
    input  logic [REG_IDX_W-1:0] rd_sel_b,
    output logic [DATA_W-1:0]    rd_data_b_c,
    input  logic [REG_IDX_W-1:0] dbg_sel,
    output logic [DATA_W-1:0]    dbg_data_c,
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] wr_sel,
    input  logic [DATA_W-1:0]    wr_data
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Storage with single write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wr_sel] <= wr_data;
        end
    end

    assign rd_data_a_c = regs_q[rd_sel_a];
    assign rd_data_b_c = regs_q[rd_sel_b];
    assign dbg_data_c  = regs_q[dbg_sel];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: four-cycle issue/writeback controller around an external
// 8-bit ALU. Accepts one instruction in IDLE, reads operands in DECODE,
// lets the ALU settle in EXEC and writes result/flags back in WB.
// Ports: clk, rst_n (async active-low);
//        instr_valid/instr_ready/instr: instruction handshake;
//        done: one-cycle writeback pulse; flag_clr/flags: {C,Z,V,U};
//        dbg_sel/dbg_data: combinational register peek;
//        alu_a/alu_b/alu_imm/alu_use_imm/alu_op: registered ALU drive;
//        alu_result/alu_carry/alu_zero/alu_overflow/alu_underflow: ALU return.
// Build option: ALU_ISSUE_STICKY_FLAGS_EN makes V and U accumulate across
// writebacks until cleared by flag_clr.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [INSTR_W-1:0]   instr,
    output logic                 done,
    input  logic                 flag_clr,
    output logic [FLAG_W-1:0]    flags,
    input  logic [REG_IDX_W-1:0] dbg_sel,
    output logic [DATA_W-1:0]    dbg_data,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic [IMM_W-1:0]     alu_imm,
    output logic                 alu_use_imm,
    output logic [ALU_OP_W-1:0]  alu_op,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic                 alu_carry,
    input  logic                 alu_zero,
    input  logic                 alu_overflow,
    input  logic                 alu_underflow
);

    issue_state_e              state_q;
    logic                      use_imm_q;
    logic [OP_FIELD_W-1:0]     op_q;
    logic [REG_IDX_W-1:0]      rd_q;
    logic [REG_IDX_W-1:0]      rs_q;
    logic [IMM_W-1:0]          imm_q;
    logic [DATA_W-1:0]         result_q;
    alu_flags_t                flags_new_q;
    alu_flags_t                flags_q;
    alu_flags_t                flags_wb_c;
    logic [DATA_W-1:0]         rd_data_a_c;
    logic [DATA_W-1:0]         rd_data_b_c;
    logic                      wr_en_c;

    assign wr_en_c = (state_q == WB);
    assign flags   = flags_q;

    reg_file_4x8 u_reg_file (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_sel_a    (rd_q),
        .rd_data_a_c (rd_data_a_c),
        .rd_sel_b    (rs_q),
        .rd_data_b_c (rd_data_b_c),
        .dbg_sel     (dbg_sel),
        .dbg_data_c  (dbg_data),
        .wr_en       (wr_en_c),
        .wr_sel      (rd_q),
        .wr_data     (result_q)
    );

    // Flag value committed at WB; a coincident flag_clr drops old sticky bits
    always_comb begin
        flags_wb_c = flags_new_q;
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
        flags_wb_c.v = flags_new_q.v | (flags_q.v & ~flag_clr);
        flags_wb_c.u = flags_new_q.u | (flags_q.u & ~flag_clr);
`endif
    end

    // Issue FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            instr_ready <= 1'b1;
            done        <= 1'b0;
            use_imm_q   <= 1'b0;
            op_q        <= '0;
            rd_q        <= '0;
            rs_q        <= '0;
            imm_q       <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_imm     <= '0;
            alu_use_imm <= 1'b0;
            alu_op      <= ALU_ADD;
            result_q    <= '0;
            flags_new_q <= '0;
            flags_q     <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        use_imm_q   <= instr[INSTR_IMM_FLAG_BIT];
                        op_q        <= instr[INSTR_OP_MSB:INSTR_OP_LSB];
                        rd_q        <= instr[INSTR_RD_MSB:INSTR_RD_LSB];
                        rs_q        <= instr[INSTR_RS_MSB:INSTR_RS_LSB];
                        imm_q       <= instr[INSTR_IMM_MSB:INSTR_IMM_LSB];
                        instr_ready <= 1'b0;
                        state_q     <= DECODE;
                    end
                end
                DECODE: begin
                    alu_a       <= rd_data_a_c;
                    alu_b       <= rd_data_b_c;
                    alu_imm     <= imm_q;
                    alu_use_imm <= use_imm_q;
                    alu_op      <= {1'b0, op_q};
                    state_q     <= EXEC;
                end
                EXEC: begin
                    result_q    <= alu_result;
                    flags_new_q <= '{c: alu_carry, z: alu_zero,
                                     v: alu_overflow, u: alu_underflow};
                    done        <= 1'b1;
                    state_q     <= WB;
                end
                WB: begin
                    instr_ready <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    instr_ready <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase

            if (state_q == WB) begin
                flags_q <= flags_wb_c;
            end else if (flag_clr) begin
                flags_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: stands in for the external ALU, keeps a
// transaction-level reference of registers/flags/handshake timing, and checks
// the DUT against it every cycle plus hand-computed directed expectations.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = 16'h0000;
    logic        done;
    logic        flag_clr = 1'b0;
    logic [3:0]  flags;
    logic [1:0]  dbg_sel = 2'd0;
    logic [7:0]  dbg_data;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_imm;
    logic        alu_use_imm;
    logic [3:0]  alu_op;
    logic [7:0]  alu_result;
    logic        alu_carry, alu_zero, alu_overflow, alu_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .done          (done),
        .flag_clr      (flag_clr),
        .flags         (flags),
        .dbg_sel       (dbg_sel),
        .dbg_data      (dbg_data),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_imm       (alu_imm),
        .alu_use_imm   (alu_use_imm),
        .alu_op        (alu_op),
        .alu_result    (alu_result),
        .alu_carry     (alu_carry),
        .alu_zero      (alu_zero),
        .alu_overflow  (alu_overflow),
        .alu_underflow (alu_underflow)
    );

    // Behavioural ALU: returns {result, C, Z, V, U}
    function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] imm, input logic use_imm,
                                           input logic [3:0] op);
        logic [7:0]  opb;
        logic [8:0]  s;
        logic [15:0] sh;
        logic [7:0]  r;
        logic        c, v, u;
        opb = use_imm ? {4'h0, imm} : b;
        c = 1'b0; v = 1'b0; u = 1'b0; r = 8'h00;
        case (op)
            4'd0: begin s = {1'b0, a} + {1'b0, opb}; r = s[7:0]; c = s[8]; v = s[8]; end
            4'd1: begin r = a - opb; u = (a < opb); end
            4'd2: r = a & opb;
            4'd3: r = a | opb;
            4'd4: r = a ^ opb;
            4'd5: r = ~a;
            4'd6: begin sh = {8'h00, a} << opb; r = sh[7:0]; c = (sh[15:8] != 8'h00); end
            4'd7: r = a >> opb;
            default: r = 8'h00;
        endcase
        return {r, c, (r == 8'h00), v, u};
    endfunction

    always_comb begin
        {alu_result, alu_carry, alu_zero, alu_overflow, alu_underflow} =
            alu_fn(alu_a, alu_b, alu_imm, alu_use_imm, alu_op);
    end

    // Reference: cycle numbers count edges since reset; acc is the accept edge
    logic [7:0] m_regs [4] = '{default: 8'h00};
    logic [3:0] m_flags = 4'h0;
    logic [7:0] m_a = 8'h00, m_b = 8'h00;
    logic [3:0] m_imm = 4'h0, m_op = 4'h0;
    logic       m_use = 1'b0;
    logic [7:0] p_a = 8'h00, p_b = 8'h00, p_res = 8'h00;
    logic [3:0] p_imm = 4'h0, p_op = 4'h0, p_fl = 4'h0;
    logic       p_use = 1'b0;
    logic [1:0] p_rd = 2'd0;
    int         cyc = 0;
    int         acc = -100;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_regs[i] <= 8'h00;
            m_flags <= 4'h0;
            m_a <= 8'h00; m_b <= 8'h00; m_imm <= 4'h0; m_op <= 4'h0; m_use <= 1'b0;
            cyc <= 0;
            acc <= -100;
        end else begin
            cyc <= cyc + 1;
            if (cyc + 1 == acc + 1) begin
                m_a <= p_a; m_b <= p_b; m_imm <= p_imm; m_op <= p_op; m_use <= p_use;
            end
            if (cyc + 1 == acc + 3) begin
                m_regs[p_rd] <= p_res;
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
                m_flags <= {p_fl[3:2], p_fl[1:0] | (flag_clr ? 2'b00 : m_flags[1:0])};
`else
                m_flags <= p_fl;
`endif
            end else if (flag_clr) begin
                m_flags <= 4'h0;
            end
            if (!(cyc >= acc && cyc <= acc + 2) && instr_valid) begin
                acc   <= cyc + 1;
                p_rd  <= instr[11:10];
                p_a   <= m_regs[instr[11:10]];
                p_b   <= m_regs[instr[9:8]];
                p_imm <= instr[3:0];
                p_use <= instr[15];
                p_op  <= {1'b0, instr[14:12]};
                {p_res, p_fl} <= alu_fn(m_regs[instr[11:10]], m_regs[instr[9:8]],
                                        instr[3:0], instr[15], {1'b0, instr[14:12]});
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the reference
    always @(negedge clk) begin
        chk("instr_ready", 16'(instr_ready), 16'(!(cyc >= acc && cyc <= acc + 2)));
        chk("done",        16'(done),        16'(cyc == acc + 2));
        chk("flags",       16'(flags),       16'(m_flags));
        chk("alu_a",       16'(alu_a),       16'(m_a));
        chk("alu_b",       16'(alu_b),       16'(m_b));
        chk("alu_imm",     16'(alu_imm),     16'(m_imm));
        chk("alu_use_imm", 16'(alu_use_imm), 16'(m_use));
        chk("alu_op",      16'(alu_op),      16'(m_op));
        chk("dbg_data",    16'(dbg_data),    16'(m_regs[dbg_sel]));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] w, input bit hold, input bit clr_at_wb);
        logic [2:0] d;
        logic [2:0] r;
        int waited;
        waited = 0;
        while (!instr_ready && waited < 20) begin
            tick();
            waited++;
        end
        chk("ready_before_issue", 16'(instr_ready), 16'h1);
        instr = w;
        instr_valid = 1'b1;
        tick();
        if (!hold) instr_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) flag_clr = clr_at_wb;
            d[k] = done;
            r[k] = instr_ready;
            tick();
            flag_clr = 1'b0;
        end
        instr_valid = 1'b0;
        chk("done_in_wb_only", 16'(d), 16'h4);
        chk("ready_low_busy",  16'(r), 16'h0);
    endtask

    task automatic lit_reg(input string name, input int idx, input logic [7:0] exp);
        dbg_sel = 2'(idx);
        #1;
        chk(name, 16'(dbg_data), 16'(exp));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ready", 16'(instr_ready), 16'h1);
        chk("rst_done",  16'(done),        16'h0);
        chk("rst_flags", 16'(flags),       16'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 16'(instr_ready), 16'h1);
        chk("rst_done",  16'(done),        16'h0);
        chk("rst_flags", 16'(flags),       16'h0);
        chk("rst_alu",   {alu_a, alu_b},   16'h0000);
        chk("rst_alu_ctl", 16'({alu_imm, alu_use_imm, alu_op}), 16'h0);
        for (int i = 0; i < 4; i++) lit_reg("rst_reg", i, 8'h00);
        rst_n = 1'b1;
        tick();

        issue(16'h840F, 1'b0, 1'b0);
        lit_reg("addi_r1", 1, 8'h0F);
        chk("addi_flags", 16'(flags), 16'h0);
        chk("addi_op", 16'(alu_op), 16'h0);
        chk("addi_use_imm", 16'(alu_use_imm), 16'h1);
        chk("addi_imm", 16'(alu_imm), 16'hF);

        issue(16'hE403, 1'b0, 1'b0);
        lit_reg("shl_r1", 1, 8'h78);
        issue(16'h0500, 1'b0, 1'b0);
        lit_reg("add1_r1", 1, 8'hF0);
        chk("add1_flags", 16'(flags), 16'h0);
        issue(16'h0500, 1'b0, 1'b0);
        lit_reg("add2_r1", 1, 8'hE0);
        chk("add2_flags", 16'(flags), 16'hA);

        do_reset();
        issue(16'h840F, 1'b0, 1'b0);
        issue(16'h1900, 1'b0, 1'b0);
        lit_reg("sub_r2", 2, 8'hF1);
        chk("sub_flags", 16'(flags), 16'h1);
        issue(16'h4500, 1'b0, 1'b0);
        lit_reg("xor_r1", 1, 8'h00);
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
        chk("xor_flags", 16'(flags), 16'h5);
`else
        chk("xor_flags", 16'(flags), 16'h4);
`endif
        issue(16'h8C01, 1'b0, 1'b0);
        lit_reg("addi_r3", 3, 8'h01);
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
        chk("addi_r3_flags", 16'(flags), 16'h1);
`else
        chk("addi_r3_flags", 16'(flags), 16'h0);
`endif
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        chk("clr_idle_flags", 16'(flags), 16'h0);

        // R0 write, then a flag_clr landing exactly on WB
        issue(16'h840F, 1'b0, 1'b0);
        issue(16'h1100, 1'b0, 1'b0);
        lit_reg("sub_r0", 0, 8'hF1);
        chk("sub_r0_flags", 16'(flags), 16'h1);
        issue(16'h1100, 1'b0, 1'b1);
        lit_reg("sub_r0_clr", 0, 8'hE2);
        chk("clr_wb_flags", 16'(flags), 16'h0);

        // Reset during EXEC discards the instruction
        do_reset();
        instr = 16'h840F;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("exec_rst_ready", 16'(instr_ready), 16'h1);
        chk("exec_rst_done",  16'(done),        16'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("exec_rst_no_done", 16'(done), 16'h0);
            tick();
        end
        lit_reg("exec_rst_r1", 1, 8'h00);

        // instr_valid held through the whole transaction: one capture only
        issue(16'h840F, 1'b1, 1'b0);
        lit_reg("hold_r1", 1, 8'h0F);
        instr = 16'h0500;
        for (int k = 0; k < 4; k++) begin
            chk("hold_ready", 16'(instr_ready), 16'h1);
            chk("hold_no_done", 16'(done), 16'h0);
            tick();
        end
        lit_reg("hold_r1_after", 1, 8'h0F);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
